nibble_seq_mult: RTL and testbench
==================================

NIBBLE_SEQ_MULT -- requirements
Module: nibble_seq_mult

Interface
REQ-001 Parameter WIDTH, default 8; operand width in bits; SHALL be a multiple of 4, minimum 4.
REQ-002 Parameter SIGNED_EN, default 1; 1 = signed_mode honoured, 0 = signed_mode ignored (always unsigned).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 clear  input  1  synchronous abort of the current operation.
REQ-006 signed_mode  input  1  1 = two's-complement operands; sampled with first A nibble.
REQ-007 in_valid  input  1  in_nibble holds valid data.
REQ-008 in_nibble  input  4  operand nibble, least-significant first.
REQ-009 in_ready  output  1  block accepts a nibble this cycle.
REQ-010 out_valid  output  1  out_nibble holds a valid product nibble.
REQ-011 out_ready  input  1  consumer accepts out_nibble this cycle.
REQ-012 out_nibble  output  4  product nibble, least-significant first.
REQ-013 busy  output  1  high in CALC and SIGN states.

Function
REQ-014 States: LOAD_A, LOAD_B, CALC, SIGN, SEND; one-hot or binary at implementer's choice.
REQ-015 Nibble transfer on an edge where in_valid and in_ready are both high; in_ready high only in LOAD_A/LOAD_B; in_valid ignored otherwise.
REQ-016 LOAD_A accepts WIDTH/4 nibbles into A at positions 0..WIDTH/4-1, then moves to LOAD_B; LOAD_B does the same for B, then moves to CALC.
REQ-017 Mode latched on first A nibble: signed = signed_mode & SIGNED_EN; held until operation ends.
REQ-018 Signed mode: A and B converted to magnitudes on entry to CALC; result sign = sign(A) XOR sign(B).
REQ-019 CALC: radix-2 shift-add, one multiplier bit per cycle, exactly WIDTH cycles, 2*WIDTH-bit accumulator, no overflow possible.
REQ-020 SIGN: one cycle; product negated (two's complement, 2*WIDTH bits) when result sign set, else unchanged; then SEND.
REQ-021 out_valid rises exactly WIDTH+1 edges after the edge accepting the last B nibble.
REQ-022 SEND emits 2*WIDTH/4 nibbles LS first; advances on out_valid & out_ready; after last, returns to LOAD_A with in_ready high next cycle.
REQ-023 While out_valid high and out_ready low, out_nibble and out_valid SHALL hold stable.
REQ-024 Product SHALL equal exact A*B in 2*WIDTH bits; signed most-negative squared (e.g. -128*-128) SHALL be correct.
REQ-025 clear high on an edge: state -> LOAD_A, nibble counters 0, out_valid 0; clear wins over any simultaneous in/out handshake (nothing transferred).
REQ-026 out_nibble SHALL be 0 whenever out_valid is low.

Reset
REQ-027 rst_n low: immediately state LOAD_A, counters, A, B, accumulator, mode 0; in_ready 1, out_valid 0, out_nibble 0, busy 0.
REQ-028 rst_n asserted mid-operation SHALL discard all partial data; first accepted nibble after release is A nibble 0.

Verification (WIDTH=8, SIGNED_EN=1)
REQ-029 Unsigned 0xFF*0xFF: in F,F,F,F -> out 1,0,E,F (0xFE01), out_valid 9 edges after last input.
REQ-030 Signed 0x80*0x80: in 0,8,0,8 -> out 0,0,0,4 (0x4000).
REQ-031 Signed 0xFD*0x07: in D,F,7,0 -> out B,E,F,F (0xFFEB = -21); same inputs unsigned -> 0x06EB.
REQ-032 out_ready low 5 cycles during SEND -> out_valid stays 1, out_nibble unchanged, no nibble lost.
REQ-033 clear during CALC -> busy 0, in_ready 1 next cycle, no out_valid; then 0x03*0x05 -> F,0,0,0.
REQ-034 rst_n low mid-SEND -> out_valid 0 and in_ready 1 without a clock edge; next op correct.

Source files
------------

// File: rtl/nibble_seq_mult.sv
// nibble_seq_mult
// Serial-in / serial-out sequential multiplier. Two WIDTH-bit operands arrive
// as 4-bit nibbles, least-significant first (A then B). The product is built
// by a radix-2 shift-add loop of WIDTH cycles. An optional sign fix-up cycle
// follows, and the 2*WIDTH-bit result is then streamed out as nibbles,
// least-significant first.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   clear        synchronous abort; returns to LOAD_A, beats any handshake
//   signed_mode  two's-complement operands; sampled with the first A nibble
//   in_valid     in_nibble carries data
//   in_nibble    operand nibble, LS first
//   in_ready     a nibble is accepted this cycle (LOAD_A / LOAD_B only)
//   out_valid    out_nibble carries a product nibble
//   out_ready    consumer takes out_nibble this cycle
//   out_nibble   product nibble, LS first; 0 while out_valid is low
//   busy         high while computing (CALC and SIGN)
module nibble_seq_mult #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       signed_mode,
  input  logic       in_valid,
  input  logic [3:0] in_nibble,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_nibble,
  output logic       busy
);

  localparam int NIB_IN  = WIDTH / 4;
  localparam int NIB_OUT = WIDTH / 2;
  localparam int PW      = 2 * WIDTH;
  localparam int CW      = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, CALC, SIGN, SEND} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic             mode_signed;
  logic             neg;

  logic [WIDTH-1:0] ld_word;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    acc_final;

  // Magnitude of an operand. The most negative value maps onto itself, which
  // read as unsigned is the correct magnitude (e.g. 0x80 -> 128).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                           input logic en);
    return (en && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Operand word being loaded, with the incoming nibble placed at the slot
  // selected by the nibble counter.
  always_comb begin
    ld_word = (state == LOAD_A) ? a_reg : b_reg;
    for (int i = 0; i < NIB_IN; i++) begin
      if (cnt == CW'(i)) ld_word[4*i +: 4] = in_nibble;
    end
  end

  // acc holds {partial sum, remaining multiplier bits}. Each step adds A to
  // the upper half when the multiplier LSB is set, then shifts right by one.
  always_comb begin
    sum       = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (acc[0] ? a_reg : '0)};
    acc_final = neg ? (~acc + PW'(1)) : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      mode_signed <= 1'b0;
      neg         <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_nibble  <= '0;
      busy        <= 1'b0;
    end else if (clear) begin
      state       <= LOAD_A;
      cnt         <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      acc         <= '0;
      mode_signed <= 1'b0;
      neg         <= 1'b0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_nibble  <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (in_valid) begin
            a_reg <= ld_word;
            if (cnt == '0) mode_signed <= signed_mode & SIGNED_EN;
            if (cnt == CW'(NIB_IN - 1)) begin
              cnt   <= '0;
              state <= LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        LOAD_B: begin
          if (in_valid) begin
            b_reg <= ld_word;
            if (cnt == CW'(NIB_IN - 1)) begin
              // Operands become magnitudes here; the sign is reapplied in SIGN.
              a_reg    <= mag(a_reg, mode_signed);
              acc      <= {{WIDTH{1'b0}}, mag(ld_word, mode_signed)};
              neg      <= mode_signed & (a_reg[WIDTH-1] ^ ld_word[WIDTH-1]);
              cnt      <= '0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
              state    <= CALC;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        CALC: begin
          acc <= {sum, acc[WIDTH-1:1]};
          if (cnt == CW'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= SIGN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        SIGN: begin
          acc        <= acc_final;
          out_nibble <= acc_final[3:0];
          out_valid  <= 1'b1;
          busy       <= 1'b0;
          state      <= SEND;
        end

        SEND: begin
          if (out_ready) begin
            if (cnt == CW'(NIB_OUT - 1)) begin
              state       <= LOAD_A;
              cnt         <= '0;
              a_reg       <= '0;
              b_reg       <= '0;
              acc         <= '0;
              mode_signed <= 1'b0;
              neg         <= 1'b0;
              in_ready    <= 1'b1;
              out_valid   <= 1'b0;
              out_nibble  <= '0;
            end else begin
              acc        <= acc >> 4;
              out_nibble <= acc[7:4];
              cnt        <= cnt + 1'b1;
            end
          end
        end

        default: begin
          state    <= LOAD_A;
          cnt      <= '0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_seq_mult.sv
// tb_nibble_seq_mult
// Directed-vector bench for nibble_seq_mult (WIDTH=8, SIGNED_EN=1).
// Inputs change on the falling edge and outputs are sampled there too, well
// away from the rising edge that the design acts on.
module tb_nibble_seq_mult;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       signed_mode;
  logic       in_valid;
  logic [3:0] in_nibble;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_nibble;
  logic       busy;

  int total = 0;
  int bad   = 0;

  nibble_seq_mult #(.WIDTH(8), .SIGNED_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .signed_mode(signed_mode),
    .in_valid   (in_valid),
    .in_nibble  (in_nibble),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nibble (out_nibble),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Feeds A (two nibbles) then B (two nibbles); called and returns on a
  // falling edge, just after the edge that took the last B nibble.
  task automatic applyStimulus(input logic [3:0] n0, input logic [3:0] n1,
                               input logic [3:0] n2, input logic [3:0] n3,
                               input logic sm);
    logic [3:0] nib [4];
    nib[0] = n0; nib[1] = n1; nib[2] = n2; nib[3] = n3;
    for (int i = 0; i < 4; i++) begin
      int guard;
      guard       = 0;
      in_valid    = 1'b1;
      in_nibble   = nib[i];
      signed_mode = sm;
      while (!in_ready && guard < 40) begin
        @(posedge clk); @(negedge clk);
        guard++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid  = 1'b0;
    in_nibble = 4'h0;
  endtask

  // Counts rising edges until out_valid appears, bounded.
  task automatic waitOut(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  // Collects four product nibbles; optionally stalls 5 cycles after nibble
  // index 'stall' and checks that the output holds.
  task automatic collect(input string tag, input int stall,
                         output logic [15:0] prod);
    prod = '0;
    for (int k = 0; k < 4; k++) begin
      int g;
      g = 0;
      while (!out_valid && g < 20) begin
        @(posedge clk); @(negedge clk);
        g++;
      end
      prod[4*k +: 4] = out_nibble;
      if (k == stall) begin
        logic       held;
        logic [3:0] saved;
        held      = 1'b1;
        saved     = out_nibble;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(posedge clk); @(negedge clk);
          if (out_valid !== 1'b1 || out_nibble !== saved) held = 1'b0;
        end
        out_ready = 1'b1;
        checkOutput({tag, "_stall_hold"}, 32'(held), 32'd1);
      end
      @(posedge clk); @(negedge clk);
    end
  endtask

  task automatic runOp(input string tag, input logic [3:0] n0,
                       input logic [3:0] n1, input logic [3:0] n2,
                       input logic [3:0] n3, input logic sm,
                       input logic [15:0] expected, input int stall);
    int          lat;
    logic [15:0] prod;
    applyStimulus(n0, n1, n2, n3, sm);
    waitOut(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd9);
    collect(tag, stall, prod);
    checkOutput({tag, "_product"}, 32'(prod), 32'(expected));
    checkOutput({tag, "_idle_after"}, {29'd0, in_ready, out_valid, |out_nibble},
                32'b100);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst_n       = 1'b0;
    clear       = 1'b0;
    signed_mode = 1'b0;
    in_valid    = 1'b0;
    in_nibble   = 4'h0;
    out_ready   = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_state", {27'd0, in_ready, out_valid, out_nibble == 4'h0, busy, 1'b0},
                32'b10100);
    rst_n = 1'b1;
    @(negedge clk);

    runOp("u_ff_ff",   4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 16'hFE01, -1);
    runOp("s_ff_ff",   4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 16'h0001, -1);
    runOp("s_80_80",   4'h0, 4'h8, 4'h0, 4'h8, 1'b1, 16'h4000, -1);
    runOp("s_fd_07",   4'hD, 4'hF, 4'h7, 4'h0, 1'b1, 16'hFFEB, -1);
    runOp("u_fd_07",   4'hD, 4'hF, 4'h7, 4'h0, 1'b0, 16'h06EB, 1);
    runOp("s_7f_80",   4'hF, 4'h7, 4'h0, 4'h8, 1'b1, 16'hC080, -1);

    // Abort in the middle of CALC.
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    @(posedge clk); @(negedge clk);
    checkOutput("calc_busy", 32'(busy), 32'd1);
    clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    checkOutput("clear_state", {29'd0, busy, in_ready, out_valid}, 32'b010);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checkOutput("clear_no_output", 32'(seen), 32'd0);
    runOp("u_03_05",   4'h3, 4'h0, 4'h5, 4'h0, 1'b0, 16'h000F, -1);

    // Asynchronous reset while sending: outputs drop with no clock edge.
    applyStimulus(4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
    waitOut(lat);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", {28'd0, in_ready, out_valid, |out_nibble, busy},
                32'b1000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    runOp("s_7f_80_b", 4'hF, 4'h7, 4'h0, 4'h8, 1'b1, 16'hC080, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
